// File: rtl/phase_sequencer.sv
// ---------------------------------------------------------------------------
// phase_sequencer
//
// Core phase controller. Walks each instruction through the one-hot phase
// strobes FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK and feeds
// top_fetch and the later pipeline stages. It handles:
//   - fetch and memory stalls (the FSM holds the phase while the stall is up),
//   - halt after the current instruction, and resume from HALT,
//   - a stall watchdog that forces HALT when one phase stalls too long,
//   - a free-running cycle counter and a retired-instruction counter.
//
// Ports
//   clk             global clock
//   rst_n           asynchronous, active-HIGH reset (legacy name kept)
//   run_en          allows leaving IDLE / chaining from WRITEBACK to FETCH
//   stall_fetch     hold FETCH (only observed in FETCH)
//   stall_memory    hold MEMORY (only observed in MEMORY)
//   halt_req        go to HALT after this instruction (observed in WRITEBACK)
//   resume          leave HALT towards FETCH (observed in HALT)
//   phase_*         one-hot phase strobes, registered
//   inst_retired    one-cycle pulse in the cycle after WRITEBACK
//   halted          high while in HALT
//   stall_timeout   sticky watchdog flag, cleared only by reset
//   cycle_count     clocks since reset, wraps
//   instret_count   retired instructions, wraps
// ---------------------------------------------------------------------------
module phase_sequencer #(
    parameter int CNT_WIDTH   = 64,
    parameter int STALL_LIMIT = 15,
    parameter int STALL_CW    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run_en,
    input  logic                 stall_fetch,
    input  logic                 stall_memory,
    input  logic                 halt_req,
    input  logic                 resume,
    output logic                 phase_fetch,
    output logic                 phase_decode,
    output logic                 phase_execute,
    output logic                 phase_memory,
    output logic                 phase_writeback,
    output logic                 inst_retired,
    output logic                 halted,
    output logic                 stall_timeout,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instret_count
);

    // Encoding order matters: FETCH..WRITEBACK are 1..5 so that phase bit gi
    // corresponds to state value gi+1 in the strobe decoder below.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } state_t;

    localparam int NUM_PHASES = 5;
    localparam logic [STALL_CW-1:0] STALL_MAX = STALL_CW'(STALL_LIMIT);

    state_t                  state_reg;
    state_t                  state_next;
    logic [STALL_CW-1:0]     stall_cnt_reg;
    logic [STALL_CW-1:0]     stall_cnt_next;
    logic [NUM_PHASES-1:0]   phase_reg;
    logic [NUM_PHASES-1:0]   phase_next;
    logic                    retired_reg;
    logic                    halted_reg;
    logic                    timeout_reg;
    logic [CNT_WIDTH-1:0]    cycle_cnt_reg;
    logic [CNT_WIDTH-1:0]    instret_cnt_reg;

    logic                    stalled;      // current phase's own stall input is up
    logic                    timeout_hit;  // watchdog fires this cycle
    logic                    leaving_wb;   // WRITEBACK always lasts one cycle

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        stalled     = 1'b0;
        timeout_hit = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (run_en) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (stall_fetch) begin
                    stalled = 1'b1;
                end else begin
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_next = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                state_next = ST_MEMORY;
            end
            ST_MEMORY: begin
                if (stall_memory) begin
                    stalled = 1'b1;
                end else begin
                    state_next = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: begin
                // A pending halt beats run_en so that ebreak/ecall stops here.
                if (halt_req) begin
                    state_next = ST_HALT;
                end else if (run_en) begin
                    state_next = ST_FETCH;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_next = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // The counter holds the number of stall cycles already spent in this
        // phase; a further stall once it reaches the limit is one too many.
        if (stalled && (stall_cnt_reg == STALL_MAX)) begin
            timeout_hit = 1'b1;
            state_next  = ST_HALT;
        end

        // Any state change (including a watchdog-forced HALT) clears it.
        if (stalled && !timeout_hit) begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
        end else begin
            stall_cnt_next = '0;
        end
    end

    assign leaving_wb = (state_reg == ST_WRITEBACK);

    // Phase strobes are decoded from the next state so that the registered
    // strobe is exactly aligned with the registered state.
    generate
        for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_phase_dec
            assign phase_next[gi] = (state_next == state_t'(3'(gi + 1)));
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_reg       <= ST_IDLE;
            stall_cnt_reg   <= '0;
            phase_reg       <= '0;
            retired_reg     <= 1'b0;
            halted_reg      <= 1'b0;
            timeout_reg     <= 1'b0;
            cycle_cnt_reg   <= '0;
            instret_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            stall_cnt_reg <= stall_cnt_next;
            phase_reg     <= phase_next;
            retired_reg   <= leaving_wb;
            halted_reg    <= (state_next == ST_HALT);
            timeout_reg   <= timeout_reg | timeout_hit;
            cycle_cnt_reg <= cycle_cnt_reg + 1'b1;
            if (leaving_wb) begin
                instret_cnt_reg <= instret_cnt_reg + 1'b1;
            end
        end
    end

    assign phase_fetch     = phase_reg[0];
    assign phase_decode    = phase_reg[1];
    assign phase_execute   = phase_reg[2];
    assign phase_memory    = phase_reg[3];
    assign phase_writeback = phase_reg[4];
    assign inst_retired    = retired_reg;
    assign halted          = halted_reg;
    assign stall_timeout   = timeout_reg;
    assign cycle_count     = cycle_cnt_reg;
    assign instret_count   = instret_cnt_reg;

endmodule
